// File: rtl/async_rr_arbiter.sv
// async_rr_arbiter
//   Merges N_CH upstream 4-phase req/ack channels onto a single downstream
//   4-phase req/ack channel using rotating (round-robin) priority. Exactly one
//   upstream channel owns the downstream link for each full handshake.
//
//   Optional build macro: ASYNC_RR_ARBITER_SYNC_EN
//     defined   -> req_i and ack_i each pass through a 2-flop synchronizer
//                  (adds 2 cycles to every input-to-output latency)
//     undefined -> inputs feed the FSM directly and must be synchronous to clk
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   req_i        upstream requests, one bit per channel
//   ack_o        upstream acknowledges, at most one bit high
//   req_o        downstream request
//   ack_i        downstream acknowledge
//   grant_o      index of the current owner, valid while busy_o=1
//   busy_o       high whenever a handshake is in progress (state != IDLE)
//   proto_err_o  sticky protocol-violation flag, cleared only by rst
module async_rr_arbiter #(
  parameter  int N_CH = 4,
  localparam int IDW  = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req_i,
  output logic [N_CH-1:0] ack_o,
  output logic            req_o,
  input  logic            ack_i,
  output logic [IDW-1:0]  grant_o,
  output logic            busy_o,
  output logic            proto_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, ACK, REL} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [IDW-1:0]  grant_nxt;
  logic [N_CH-1:0] ack_nxt;
  logic            req_nxt, busy_nxt, err_nxt;

  // Input views seen by the FSM (raw or synchronized).
  logic [N_CH-1:0] req_s;
  logic            ack_s;

`ifdef ASYNC_RR_ARBITER_SYNC_EN
  logic [N_CH-1:0] req_m;
  logic            ack_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_m <= '0;
      req_s <= '0;
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      req_m <= req_i;
      req_s <= req_m;
      ack_m <= ack_i;
      ack_s <= ack_m;
    end
  end
`else
  assign req_s = req_i;
  assign ack_s = ack_i;
`endif

  // Round-robin winner: first pending channel at or after ptr. Scanning the
  // offsets from farthest to nearest lets the nearest one overwrite the rest.
  logic           any_req;
  logic [IDW-1:0] winner;
  int             scan_idx;

  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned; a missing default would infer a latch.
    any_req  = 1'b0;
    winner   = ptr;
    scan_idx = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      scan_idx = (int'(ptr) + i) % N_CH;
      if (req_s[IDW'(scan_idx)]) begin
        any_req = 1'b1;
        winner  = IDW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant_o;
    ack_nxt   = ack_o;
    req_nxt   = req_o;
    busy_nxt  = busy_o;
    err_nxt   = proto_err_o;
    case (state)
      IDLE: begin
        // A still-high ack_i (e.g. left over from before a reset) blocks any
        // new grant so the downstream cannot see a false completion.
        if (any_req && !ack_s) begin
          grant_nxt = winner;
          req_nxt   = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // Owner withdrew before being acknowledged: flag it, but req_o must
        // stay high because a 4-phase request cannot be retracted.
        if (!req_s[grant_o]) err_nxt = 1'b1;
        if (ack_s) begin
          ack_nxt   = N_CH'(1) << grant_o;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (!ack_s) begin
          err_nxt = 1'b1;
        end else if (!req_s[grant_o]) begin
          req_nxt   = 1'b0;
          state_nxt = REL;
        end
      end
      REL: begin
        if (!ack_s) begin
          ack_nxt   = '0;
          busy_nxt  = 1'b0;
          ptr_nxt   = (grant_o == IDW'(N_CH - 1)) ? '0 : grant_o + 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_o     <= '0;
      ack_o       <= '0;
      req_o       <= 1'b0;
      busy_o      <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant_o     <= grant_nxt;
      ack_o       <= ack_nxt;
      req_o       <= req_nxt;
      busy_o      <= busy_nxt;
      proto_err_o <= err_nxt;
    end
  end

endmodule

// File: tb/tb_async_rr_arbiter.sv
// Self-checking bench for async_rr_arbiter (N_CH=4). Expected grant indices
// are queued when requests are driven and popped when req_o rises.
module tb_async_rr_arbiter;

  localparam int N_CH = 4;
  localparam int IDW  = 2;
`ifdef ASYNC_RR_ARBITER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] req_i = '0;
  logic [N_CH-1:0] ack_o;
  logic            req_o;
  logic            ack_i = 1'b0;
  logic [IDW-1:0]  grant_o;
  logic            busy_o;
  logic            proto_err_o;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  async_rr_arbiter #(.N_CH(N_CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .ack_o      (ack_o),
    .req_o      (req_o),
    .ack_i      (ack_i),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .proto_err_o(proto_err_o)
  );

  // Upstream acks: only the owner's bit may ever be set.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (ack_o !== '0 && ack_o !== (4'b0001 << grant_o)) begin
        errors++;
        $display("FAIL ack_onehot: ack_o=%b grant_o=%0d", ack_o, grant_o);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return req_o;
      1:       return busy_o;
      2:       return |ack_o;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int sel, input logic val, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (sig(sel) !== val) begin
      if (n == 30) begin
        ok = 1'b0;
        return;
      end
      tick(1);
      n++;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_i = '0;
    ack_i = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  // Completes one handshake for the next expected owner.
  task automatic serve_one(input bit rearm);
    int g;
    bit ok;
    g = exp_q.pop_front();
    wait_until(0, 1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL serve_req_rise: timeout waiting for req_o=1 (owner %0d)", g); end
    checks++;
    if (grant_o !== IDW'(g)) begin errors++; $display("FAIL serve_grant: got %0d expected %0d", grant_o, g); end
    ack_i = 1'b1;
    wait_until(2, 1'b1, ok);
    checks++;
    if (ack_o !== (4'b0001 << g)) begin errors++; $display("FAIL serve_ack: ack_o=%b expected %b (ok=%0d)", ack_o, 4'b0001 << g, ok); end
    req_i[g] = 1'b0;
    wait_until(0, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL serve_req_fall: timeout waiting for req_o=0"); end
    ack_i = 1'b0;
    wait_until(1, 1'b0, ok);
    checks++;
    if (!ok || ack_o !== '0) begin errors++; $display("FAIL serve_release: busy_o=%b ack_o=%b expected 0/0", busy_o, ack_o); end
    if (rearm) req_i[g] = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req_i = 4'b1111;
    ack_i = 1'b0;
    tick(2);
    checks++;
    if ({ack_o, req_o, grant_o, busy_o, proto_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_values: ack=%b req=%b grant=%0d busy=%b err=%b expected all 0",
               ack_o, req_o, grant_o, busy_o, proto_err_o);
    end
    do_reset();
  endtask

  task automatic test_single();
    int g;
    req_i = 4'b0100;
    exp_q.push_back(2);
    tick(LAT - 1);
    checks++;
    if (req_o !== 1'b0) begin errors++; $display("FAIL single_req_early: req_o=%b expected 0", req_o); end
    tick(1);
    g = exp_q.pop_front();
    checks++;
    if (req_o !== 1'b1 || busy_o !== 1'b1 || grant_o !== IDW'(g)) begin
      errors++;
      $display("FAIL single_grant: req_o=%b busy_o=%b grant_o=%0d expected 1/1/%0d", req_o, busy_o, grant_o, g);
    end
    ack_i = 1'b1;
    tick(LAT - 1);
    checks++;
    if (ack_o !== 4'b0000) begin errors++; $display("FAIL single_ack_early: ack_o=%b expected 0000", ack_o); end
    tick(1);
    checks++;
    if (ack_o !== 4'b0100) begin errors++; $display("FAIL single_ack: ack_o=%b expected 0100", ack_o); end
    req_i = 4'b0000;
    tick(LAT - 1);
    checks++;
    if (req_o !== 1'b1) begin errors++; $display("FAIL single_req_hold: req_o=%b expected 1", req_o); end
    tick(1);
    checks++;
    if (req_o !== 1'b0) begin errors++; $display("FAIL single_req_fall: req_o=%b expected 0", req_o); end
    ack_i = 1'b0;
    tick(LAT - 1);
    checks++;
    if (ack_o !== 4'b0100) begin errors++; $display("FAIL single_ack_hold: ack_o=%b expected 0100", ack_o); end
    tick(1);
    checks++;
    if (ack_o !== 4'b0000 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_release: ack_o=%b busy_o=%b expected 0000/0", ack_o, busy_o);
    end
  endtask

  // Runs right after test_single, so the pointer sits at 3.
  task automatic test_wrap();
    req_i = 4'b1001;
    exp_q.push_back(3);
    exp_q.push_back(0);
    serve_one(1'b0);
    serve_one(1'b0);
  endtask

  task automatic test_fairness();
    do_reset();
    for (int k = 0; k < 8; k++) exp_q.push_back(k % N_CH);
    req_i = 4'b1111;
    for (int k = 0; k < 8; k++) serve_one(1'b1);
    req_i = 4'b0000;
    tick(LAT + 2);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL fair_idle: busy_o=%b expected 0", busy_o); end
  endtask

  task automatic test_stale_ack();
    bit ok;
    do_reset();
    req_i = 4'b0001;
    wait_until(0, 1'b1, ok);
    ack_i = 1'b1;
    wait_until(2, 1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stale_setup: timeout reaching ACK"); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (req_o !== 1'b0 || ack_o !== '0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL stale_reset: req_o=%b ack_o=%b busy_o=%b expected 0/0000/0", req_o, ack_o, busy_o);
    end
    for (int k = 0; k < 6; k++) begin
      tick(1);
      checks++;
      if (req_o !== 1'b0) begin errors++; $display("FAIL stale_hold: cycle %0d req_o=%b expected 0", k, req_o); end
    end
    ack_i = 1'b0;
    exp_q.push_back(0);
    tick(LAT - 1);
    checks++;
    if (req_o !== 1'b0) begin errors++; $display("FAIL stale_early: req_o=%b expected 0", req_o); end
    tick(1);
    checks++;
    if (req_o !== 1'b1) begin errors++; $display("FAIL stale_regrant: req_o=%b expected 1", req_o); end
    serve_one(1'b0);
  endtask

  task automatic test_violation();
    bit ok;
    int g;
    do_reset();
    checks++;
    if (proto_err_o !== 1'b0) begin errors++; $display("FAIL viol_clear: proto_err_o=%b expected 0", proto_err_o); end
    req_i = 4'b0010;
    exp_q.push_back(1);
    wait_until(0, 1'b1, ok);
    g = exp_q.pop_front();
    checks++;
    if (!ok || grant_o !== IDW'(g)) begin errors++; $display("FAIL viol_grant: grant_o=%0d expected %0d (ok=%0d)", grant_o, g, ok); end
    req_i = 4'b0000;
    tick(LAT - 1);
    checks++;
    if (proto_err_o !== 1'b0) begin errors++; $display("FAIL viol_early: proto_err_o=%b expected 0", proto_err_o); end
    tick(1);
    checks++;
    if (proto_err_o !== 1'b1 || req_o !== 1'b1) begin
      errors++;
      $display("FAIL viol_flag: proto_err_o=%b req_o=%b expected 1/1", proto_err_o, req_o);
    end
    tick(4);
    checks++;
    if (req_o !== 1'b1 || proto_err_o !== 1'b1 || ack_o !== '0) begin
      errors++;
      $display("FAIL viol_hold: req_o=%b err=%b ack_o=%b expected 1/1/0000", req_o, proto_err_o, ack_o);
    end
    ack_i = 1'b1;
    wait_until(2, 1'b1, ok);
    checks++;
    if (ack_o !== 4'b0010) begin errors++; $display("FAIL viol_ack: ack_o=%b expected 0010", ack_o); end
    wait_until(0, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL viol_req_fall: timeout waiting for req_o=0"); end
    ack_i = 1'b0;
    wait_until(1, 1'b0, ok);
    checks++;
    if (!ok || proto_err_o !== 1'b1) begin
      errors++;
      $display("FAIL viol_sticky: busy_o=%b proto_err_o=%b expected 0/1", busy_o, proto_err_o);
    end
    do_reset();
    checks++;
    if (proto_err_o !== 1'b0) begin errors++; $display("FAIL viol_reset: proto_err_o=%b expected 0", proto_err_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_stale_ack();
    test_violation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/async_rr_arbiter.md
Name: async_rr_arbiter

Overview:
- Clocked N-channel successor to the 2-way mutex/C-element arbiter.
- Merges N_CH upstream 4-phase req/ack channels onto one downstream 4-phase req/ack channel.
- Uses rotating (round-robin) priority; exactly one channel owns the downstream link per handshake.
- Sits between multiple requesters and a shared lock/resource controller.

Parameters:
- N_CH, 4, number of upstream channels; legal range 2..16.
- IDW, $clog2(N_CH), width of grant index (localparam, derived).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req_i  input  N_CH  upstream 4-phase requests, one bit per channel.
- ack_o  output  N_CH  upstream acknowledges; at most one bit high.
- req_o  output  1  downstream request.
- ack_i  input  1  downstream acknowledge.
- grant_o  output  IDW  index of the current owner; valid while busy_o=1.
- busy_o  output  1  high in any state other than IDLE.
- proto_err_o  output  1  sticky protocol-violation flag.

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: ack_o=0, req_o=0, grant_o=0, busy_o=0, proto_err_o=0, state=IDLE, priority pointer ptr=0.
- States: IDLE, REQ, ACK, REL.
- IDLE:
  - If any req_i bit is high and ack_i=0, select winner g = first set bit scanning ptr, ptr+1, ... mod N_CH.
  - Next edge: grant_o=g, req_o=1, busy_o=1, state=REQ.
  - If ack_i=1 in IDLE, no new grant is issued; the arbiter waits for ack_i=0. This covers a stale ack after reset.
- REQ: ack_i=1 -> next edge ack_o[g]=1, state=ACK.
- ACK: req_i[g]=0 -> next edge req_o=0, state=REL.
- REL: ack_i=0 -> next edge ack_o[g]=0, ptr=(g+1) mod N_CH, busy_o=0, state=IDLE.
- Latency (no sync):
  - req_i rise to req_o rise: 1 cycle.
  - ack_i rise to ack_o[g] rise: 1 cycle.
  - req_i[g] fall to req_o fall: 1 cycle.
  - ack_i fall to ack_o[g] fall: 1 cycle.
  - Minimum full handshake: 4 cycles plus environment delay.
  - Earliest regrant: the cycle after returning to IDLE.
- Simultaneous requests: only the winner is served. Losers stay pending and are served in rotating order; no starvation, as every pending channel is served within N_CH handshakes.
- ptr wrap-around: g=N_CH-1 sets ptr=0.
- Non-granted channels: ack_o bits of non-owners stay 0 regardless of ack_i.
- Owner request change during a handshake: other channels' req_i changes have no effect until IDLE.
- Violation: req_i[g] falling while in REQ (withdrawn before ack):
  - proto_err_o=1, sticky until rst.
  - req_o stays high (4-phase cannot retract).
  - The handshake completes; ACK then sees req_i[g]=0 and proceeds.
- Violation: ack_i falling while in ACK:
  - proto_err_o=1.
  - State is unchanged.
- Reset mid-operation: all outputs return to reset values at the next edge. The downstream may observe req_o fall with ack_i high; the IDLE rule above prevents a false completion.

Optional Feature:
- Macro: ASYNC_RR_ARBITER_SYNC_EN.
- Defined:
  - req_i and ack_i each pass through a 2-flop synchronizer (reset to 0) before the FSM.
  - Every input-to-output latency above increases by 2 cycles.
  - Protocol checks use the synchronized values.
- Undefined:
  - Inputs feed the FSM directly and must be synchronous to clk.

Test Plan:
- Single channel, N_CH=4: req_i=4'b0100 at cycle 0.
  - Expect req_o=1, grant_o=2 at cycle 1.
  - Drive ack_i=1 -> ack_o=4'b0100 one cycle later.
  - Drop req_i -> req_o=0 one cycle later.
  - Drop ack_i -> ack_o=0, busy_o=0; next ptr=3.
- Fairness: hold req_i=4'b1111 and complete 8 handshakes.
  - Expect grant_o sequence 0,1,2,3,0,1,2,3.
  - At most one ack_o bit high at any time.
- Wrap: ptr=3 via a prior grant to 2, then req_i=4'b1001.
  - Expect grant 3, then grant 0.
- Stale ack: reset while in ACK with ack_i held 1, req_i=4'b0001.
  - Expect req_o=0 until ack_i=0, then req_o=1 one cycle later.
- Violation: in REQ, drop req_i[g] before ack_i.
  - Expect proto_err_o=1 sticky.
  - req_o stays 1 until ack_i=1; the handshake completes to IDLE.
- With ASYNC_RR_ARBITER_SYNC_EN: repeat the first test.
  - Expect each transition delayed by exactly 2 extra cycles.
